// File: rtl/m6809_word_xfer_if.sv
// Request/bus bundle for the m6809 word transfer sequencer.
// The slave side is the sequencer; the master side is the datapath plus memory.
interface m6809_word_xfer_if;
   logic        start;
   logic        rw;
   logic        word;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        busy;
   logic        done;
   logic [15:0] bus_addr;
   logic        bus_rw;
   logic        bus_vma;
   logic [7:0]  bus_dout;
   logic [7:0]  bus_din;
   logic        bus_ready;

   modport slave (
      input  start, rw, word, addr, wdata, bus_din, bus_ready,
      output rdata, busy, done, bus_addr, bus_rw, bus_vma, bus_dout
   );

   modport master (
      output start, rw, word, addr, wdata, bus_din, bus_ready,
      input  rdata, busy, done, bus_addr, bus_rw, bus_vma, bus_dout
   );
endinterface

// File: rtl/m6809_word_xfer.sv
// Splits a 16-bit load/store into two big-endian byte cycles (or one byte cycle)
// on the 8-bit bus, with bus_ready wait stretching; all outputs are registered.
module m6809_word_xfer (
   input  logic             clk,
   input  logic             reset_n,
   m6809_word_xfer_if.slave xfer
);

   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

   state_t      state_q, state_d;
   logic        rw_q, rw_d;
   logic        word_q, word_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_lo_q, wdata_lo_d;
   logic [15:0] rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] bus_addr_q, bus_addr_d;
   logic        bus_rw_q, bus_rw_d;
   logic        bus_vma_q, bus_vma_d;
   logic [7:0]  bus_dout_q, bus_dout_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      rw_d       = rw_q;
      word_d     = word_q;
      addr_d     = addr_q;
      wdata_lo_d = wdata_lo_q;
      rdata_d    = rdata_q;
      busy_d     = busy_q;
      done_d     = done_q;
      bus_addr_d = bus_addr_q;
      bus_rw_d   = bus_rw_q;
      bus_vma_d  = bus_vma_q;
      bus_dout_d = bus_dout_q;

      unique case (state_q)
         IDLE: begin
            if (xfer.start) begin
               rw_d       = xfer.rw;
               word_d     = xfer.word;
               addr_d     = xfer.addr;
               wdata_lo_d = xfer.wdata[7:0];
               state_d    = HI;
               busy_d     = 1'b1;
               bus_vma_d  = 1'b1;
               bus_addr_d = xfer.addr;
               bus_rw_d   = xfer.rw;
               if (!xfer.rw)
                  bus_dout_d = xfer.word ? xfer.wdata[15:8] : xfer.wdata[7:0];
            end
         end

         HI: begin
            // Bus outputs are left untouched until the cycle completes.
            if (xfer.bus_ready) begin
               if (word_q) begin
                  state_d    = LO;
                  bus_addr_d = addr_q + 16'd1;
                  if (rw_q)
                     rdata_d[15:8] = xfer.bus_din;
                  else
                     bus_dout_d = wdata_lo_q;
               end else begin
                  state_d   = DONE;
                  done_d    = 1'b1;
                  bus_vma_d = 1'b0;
                  bus_rw_d  = 1'b1;
                  if (rw_q)
                     rdata_d = {8'h00, xfer.bus_din};
               end
            end
         end

         LO: begin
            if (xfer.bus_ready) begin
               state_d   = DONE;
               done_d    = 1'b1;
               bus_vma_d = 1'b0;
               bus_rw_d  = 1'b1;
               if (rw_q)
                  rdata_d[7:0] = xfer.bus_din;
            end
         end

         DONE: begin
            state_d = IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments only, so every flop samples the
      // pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q    <= IDLE;
         rw_q       <= 1'b1;
         word_q     <= 1'b0;
         addr_q     <= 16'h0000;
         wdata_lo_q <= 8'h00;
         rdata_q    <= 16'h0000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bus_addr_q <= 16'h0000;
         bus_rw_q   <= 1'b1;
         bus_vma_q  <= 1'b0;
         bus_dout_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         rw_q       <= rw_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         wdata_lo_q <= wdata_lo_d;
         rdata_q    <= rdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         bus_addr_q <= bus_addr_d;
         bus_rw_q   <= bus_rw_d;
         bus_vma_q  <= bus_vma_d;
         bus_dout_q <= bus_dout_d;
      end
   end

   assign xfer.rdata    = rdata_q;
   assign xfer.busy     = busy_q;
   assign xfer.done     = done_q;
   assign xfer.bus_addr = bus_addr_q;
   assign xfer.bus_rw   = bus_rw_q;
   assign xfer.bus_vma  = bus_vma_q;
   assign xfer.bus_dout = bus_dout_q;

endmodule

// File: tb/tb_m6809_word_xfer.sv
// Directed bench for m6809_word_xfer: inputs change and outputs are sampled on
// the falling edge; a byte-array memory answers bus reads.
module tb_m6809_word_xfer;

   logic clk = 1'b0;
   logic reset_n;
   int   vectors = 0;
   int   miscompares = 0;

   logic [7:0] mem [0:65535];
   logic [3:0] ctl;

   m6809_word_xfer_if bus_if ();

   m6809_word_xfer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .xfer    (bus_if)
   );

   always #5 clk = ~clk;

   assign bus_if.bus_din = mem[bus_if.bus_addr];
   assign ctl = {bus_if.busy, bus_if.done, bus_if.bus_vma, bus_if.bus_rw};

   task automatic test_reset();
      reset_n          = 1'b0;
      bus_if.start     = 1'b0;
      bus_if.rw        = 1'b1;
      bus_if.word      = 1'b1;
      bus_if.addr      = 16'h5555;
      bus_if.wdata     = 16'hAAAA;
      bus_if.bus_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (ctl !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset busy/done/vma/rw got %b want 0001", ctl);
      end
      vectors++;
      if (bus_if.bus_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset bus_addr got %h want 0000", bus_if.bus_addr);
      end
      vectors++;
      if (bus_if.bus_dout !== 8'h00) begin
         miscompares++;
         $display("FAIL reset bus_dout got %h want 00", bus_if.bus_dout);
      end
      vectors++;
      if (bus_if.rdata !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset rdata got %h want 0000", bus_if.rdata);
      end
   endtask

   // Zero-wait word read; a0 is the high-byte address, a1 the expected second address.
   task automatic test_word_read(input string name, input logic [15:0] a0,
                                 input logic [15:0] a1, input logic [7:0] hi,
                                 input logic [7:0] lo);
      logic [3:0]  exp_ctl [4];
      logic [15:0] exp_addr [4];
      exp_ctl  = '{4'b1011, 4'b1011, 4'b1101, 4'b0001};
      exp_addr = '{a0, a1, a1, a1};
      mem[a0] = hi;
      mem[a1] = lo;
      bus_if.start     = 1'b1;
      bus_if.rw        = 1'b1;
      bus_if.word      = 1'b1;
      bus_if.addr      = a0;
      bus_if.bus_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus_if.start = 1'b0;
         bus_if.addr  = 16'hDEAD;
         vectors++;
         if (ctl !== exp_ctl[c]) begin
            miscompares++;
            $display("FAIL %s ctl cyc%0d got %b want %b", name, c + 1, ctl, exp_ctl[c]);
         end
         vectors++;
         if (bus_if.bus_addr !== exp_addr[c]) begin
            miscompares++;
            $display("FAIL %s bus_addr cyc%0d got %h want %h", name, c + 1,
                     bus_if.bus_addr, exp_addr[c]);
         end
         if (c >= 2) begin
            vectors++;
            if (bus_if.rdata !== {hi, lo}) begin
               miscompares++;
               $display("FAIL %s rdata cyc%0d got %h want %h", name, c + 1,
                        bus_if.rdata, {hi, lo});
            end
         end
      end
   endtask

   // Word write with 2 wait cycles in HI and 1 in LO; rdata must keep prev_rdata.
   task automatic test_word_write_waits(input logic [15:0] prev_rdata);
      logic [3:0]  exp_ctl [7];
      logic [15:0] exp_addr [7];
      logic [7:0]  exp_dout [7];
      logic        rdy [7];
      exp_ctl  = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1101, 4'b0001};
      exp_addr = '{16'h0100, 16'h0100, 16'h0100, 16'h0101, 16'h0101, 16'h0101, 16'h0101};
      exp_dout = '{8'hBE, 8'hBE, 8'hBE, 8'hEF, 8'hEF, 8'hEF, 8'hEF};
      rdy      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      bus_if.start     = 1'b1;
      bus_if.rw        = 1'b0;
      bus_if.word      = 1'b1;
      bus_if.addr      = 16'h0100;
      bus_if.wdata     = 16'hBEEF;
      bus_if.bus_ready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         bus_if.start = 1'b0;
         bus_if.addr  = 16'h7777;
         bus_if.wdata = 16'h1111;
         vectors++;
         if (ctl !== exp_ctl[c]) begin
            miscompares++;
            $display("FAIL write ctl cyc%0d got %b want %b", c + 1, ctl, exp_ctl[c]);
         end
         vectors++;
         if (bus_if.bus_addr !== exp_addr[c]) begin
            miscompares++;
            $display("FAIL write bus_addr cyc%0d got %h want %h", c + 1,
                     bus_if.bus_addr, exp_addr[c]);
         end
         vectors++;
         if (bus_if.bus_dout !== exp_dout[c]) begin
            miscompares++;
            $display("FAIL write bus_dout cyc%0d got %h want %h", c + 1,
                     bus_if.bus_dout, exp_dout[c]);
         end
         vectors++;
         if (bus_if.rdata !== prev_rdata) begin
            miscompares++;
            $display("FAIL write rdata cyc%0d got %h want %h", c + 1,
                     bus_if.rdata, prev_rdata);
         end
         bus_if.bus_ready = rdy[c];
      end
      bus_if.rw = 1'b1;
   endtask

   // Byte read with start re-asserted during HI and DONE; neither may be accepted.
   task automatic test_byte_read_ignored_start();
      logic [3:0] exp_ctl [4];
      exp_ctl = '{4'b1011, 4'b1101, 4'b0001, 4'b0001};
      mem[16'h2000]    = 8'h80;
      mem[16'h3000]    = 8'h55;
      bus_if.start     = 1'b1;
      bus_if.rw        = 1'b1;
      bus_if.word      = 1'b0;
      bus_if.addr      = 16'h2000;
      bus_if.bus_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus_if.start = (c < 2);
         bus_if.addr  = 16'h3000;
         vectors++;
         if (ctl !== exp_ctl[c]) begin
            miscompares++;
            $display("FAIL byte ctl cyc%0d got %b want %b", c + 1, ctl, exp_ctl[c]);
         end
         vectors++;
         if (bus_if.bus_addr !== 16'h2000) begin
            miscompares++;
            $display("FAIL byte bus_addr cyc%0d got %h want 2000", c + 1, bus_if.bus_addr);
         end
         if (c >= 1) begin
            vectors++;
            if (bus_if.rdata !== 16'h0080) begin
               miscompares++;
               $display("FAIL byte rdata cyc%0d got %h want 0080", c + 1, bus_if.rdata);
            end
         end
      end
      bus_if.word = 1'b1;
   endtask

   // Reset asserted while in LO of a word write abandons it without a done pulse.
   task automatic test_mid_reset();
      bus_if.start     = 1'b1;
      bus_if.rw        = 1'b0;
      bus_if.word      = 1'b1;
      bus_if.addr      = 16'h0300;
      bus_if.wdata     = 16'h5AC3;
      bus_if.bus_ready = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      @(negedge clk);
      vectors++;
      if (ctl !== 4'b1010 || bus_if.bus_addr !== 16'h0301 || bus_if.bus_dout !== 8'hC3) begin
         miscompares++;
         $display("FAIL midreset LO ctl/addr/dout got %b/%h/%h want 1010/0301/c3",
                  ctl, bus_if.bus_addr, bus_if.bus_dout);
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      vectors++;
      if (ctl !== 4'b0001) begin
         miscompares++;
         $display("FAIL midreset ctl got %b want 0001", ctl);
      end
      vectors++;
      if (bus_if.bus_addr !== 16'h0000 || bus_if.bus_dout !== 8'h00 ||
          bus_if.rdata !== 16'h0000) begin
         miscompares++;
         $display("FAIL midreset addr/dout/rdata got %h/%h/%h want 0000/00/0000",
                  bus_if.bus_addr, bus_if.bus_dout, bus_if.rdata);
      end
      @(negedge clk);
      vectors++;
      if (ctl !== 4'b0001) begin
         miscompares++;
         $display("FAIL midreset after release ctl got %b want 0001", ctl);
      end
      bus_if.rw = 1'b1;
   endtask

   initial begin
      test_reset();
      test_word_read("word_read", 16'h1234, 16'h1235, 8'hAB, 8'hCD);
      test_word_write_waits(16'hABCD);
      test_word_read("addr_wrap", 16'hFFFF, 16'h0000, 8'h12, 8'h34);
      test_byte_read_ignored_start();
      test_mid_reset();
      test_word_read("after_reset", 16'h4000, 16'h4001, 8'h9A, 8'h7B);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/m6809_word_xfer.md
# m6809_word_xfer

Byte-bus transfer sequencer for the m6809 core. It turns one 16-bit load/store request from the execution datapath into two big-endian byte cycles on the 8-bit memory bus: high byte at `addr`, low byte at `addr+1`. On the read side it reassembles the word, which is the value the 16-bit ALU tests for LDD/LDX/LDY/LDU/LDS. On the write side it serialises the ALU result for STD/STX/STY/STU/STS. It also performs single-byte transfers and supports a wait-stretch (`bus_ready`) handshake.

## Interface
Parameters:
- none; widths are fixed by the 6809 architecture (16-bit address, 8-bit data).

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request strobe; accepted only in IDLE.
- `rw`  in  1  1 = read (load), 0 = write (store); 6809 R/W polarity.
- `word`  in  1  1 = 16-bit transfer, 0 = 8-bit transfer.
- `addr`  in  16  effective address of the high (or only) byte.
- `wdata`  in  16  store data; byte mode uses `wdata[7:0]`.
- `rdata`  out  16  load result; byte mode zero-extends to `{8'h00, byte}`.
- `busy`  out  1  high in HI, LO and DONE states.
- `done`  out  1  one-cycle completion pulse.
- `bus_addr`  out  16  memory address.
- `bus_rw`  out  1  bus direction, 1 = read.
- `bus_vma`  out  1  valid memory address; qualifies a bus cycle.
- `bus_dout`  out  8  write data.
- `bus_din`  in  8  read data; sampled on the completing edge.
- `bus_ready`  in  1  a bus cycle completes on an edge where `bus_vma & bus_ready`.

## Operation
- **States:** IDLE, HI, LO, DONE.
- **IDLE:**
  - On `start`, latch `rw`, `word`, `addr` and `wdata`, then go to HI.
  - Without `start`, stay in IDLE.
- **HI:**
  - Drive `bus_vma=1`, `bus_addr=addr`, `bus_rw=rw`.
  - For a write, drive `bus_dout` with `wdata[15:8]` when `word`, otherwise `wdata[7:0]`.
  - Hold every bus output stable while `bus_ready=0`.
  - On completion with `word=1`, go to LO; a read captures `bus_din` into `rdata[15:8]`.
  - On completion with `word=0`, go to DONE; a read sets `rdata={8'h00, bus_din}`.
- **LO:**
  - Drive `bus_addr=addr+1` (16-bit, wraps: FFFF -> 0000).
  - For a write, drive `bus_dout=wdata[7:0]`.
  - On completion, a read captures `bus_din` into `rdata[7:0]`; go to DONE.
- **DONE:**
  - `done=1` and `bus_vma=0`; always go to IDLE next cycle.
  - `start` is ignored in DONE.
- **Holding rules:**
  - Latched request fields are held for the whole transfer.
  - `start`, `addr` and `wdata` changes after acceptance have no effect.
  - `rdata` holds its value until the next read captures new data. Writes never modify `rdata`.
- **Idle bus drive:** outside HI/LO, `bus_vma=0`, `bus_rw=1`, and `bus_addr`/`bus_dout` hold their last values.

## Timing
- **Reset values:** state IDLE, `busy=0`, `done=0`, `bus_vma=0`, `bus_rw=1`, `bus_addr=16'h0000`, `bus_dout=8'h00`, `rdata=16'h0000`.
- **Reset mid-transfer:** `reset_n=0` in any state forces these values on that edge. The partial transfer is abandoned, with no `done` pulse.
- **Start edge:** `start` is sampled at edge E0; HI is visible in the cycle after E0.
- **Zero wait-state latency (`bus_ready=1`):**
  - Word: HI in cycle 1, LO in cycle 2, `done` in cycle 3.
  - Byte: HI in cycle 1, `done` in cycle 2.
- **Wait states:** each cycle with `bus_ready=0` during HI or LO adds exactly one cycle.
- **Data valid:** `rdata` is valid in the `done` cycle and after it.
- **Back-to-back:** the earliest next `start` acceptance is the IDLE cycle following `done`, giving a minimum of 4 cycles per word.
- **`bus_ready` outside HI/LO:** ignored.

## Test plan
- **Reset:** hold `reset_n=0` 2 cycles, then release -> all outputs at their reset values; `busy=0`.
- **Word read, no waits:** `addr=16'h1234`, memory `[1234]=8'hAB`, `[1235]=8'hCD` -> `bus_addr` is 1234 then 1235 with `bus_rw=1`; `rdata=16'hABCD` with `done` in cycle 3.
- **Word write with waits:** `wdata=16'hBEEF`, `addr=16'h0100`, `bus_ready` low 2 cycles in HI and 1 cycle in LO -> `bus_dout` is EF... no: `bus_dout=8'hBE` at 0100 held 3 cycles, then `8'hEF` at 0101 held 2 cycles; `done` in cycle 6; `rdata` unchanged.
- **Address wrap:** word read at `addr=16'hFFFF`, memory `[FFFF]=8'h12`, `[0000]=8'h34` -> second `bus_addr=16'h0000`; `rdata=16'h1234`.
- **Byte read and ignored starts:** byte read of `8'h80` -> `rdata=16'h0080`, `done` in cycle 2; `start` asserted during HI and during DONE is not accepted.
- **Mid-transfer reset:** assert `reset_n=0` during LO of a word write -> next cycle `bus_vma=0`, `busy=0`, no `done`; a subsequent read completes normally.
